eth_pktgen: RTL and testbench
=============================

Name: eth_pktgen

Overview:
- Parametrised AXI4-Stream Ethernet frame generator. It is the successor to the fixed 64-bit TX encapsulator.
- Drives s_axis_tx_* of the 10G/25G MAC in the clk156 domain.
- Frame length, inter-frame gap, frame count and header fields are runtime-configurable.
- Each frame carries a 32-bit sequence number, so the receive side can detect loss and reordering.

Parameters:
- DATA_WIDTH, 64: stream data width in bits; legal values 64, 128, 256.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width, one bit per byte.
- LEN_WIDTH, 14: width of frame length and byte counters.
- CNT_WIDTH, 32: width of the frame count and sent counter.

Ports:
- clk156  in  1  core clock.
- eth_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run; ignored while busy=1.
- stop  in  1  level or pulse; the current frame finishes, then the block goes to IDLE.
- cfg_frame_len  in  LEN_WIDTH  frame length in bytes, excluding FCS.
- cfg_ifg  in  8  idle cycles between frames.
- cfg_frame_cnt  in  CNT_WIDTH  frames per run; 0 means run until stop.
- cfg_dst_mac  in  48  destination MAC address.
- cfg_src_mac  in  48  source MAC address.
- cfg_ethertype  in  16  EtherType field.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tdata  out  DATA_WIDTH  frame bytes; byte 0 is in bits [7:0].
- m_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_axis_tlast  out  1  last beat of a frame.
- m_axis_tuser  out  1  always 0.
- busy  out  1  high from start until the run ends.
- sent_count  out  CNT_WIDTH  frames fully accepted since reset; wraps.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset is asynchronous and active-low, so it clears immediately, including mid-frame. A truncated frame is acceptable.
- FSM states: IDLE, DATA, GAP.
- IDLE -> DATA on start.
  - The run configuration is latched: frame_cnt, ifg and header fields.
  - busy rises one cycle after start, and m_axis_tvalid rises on the same cycle.
- Frame length:
  - cfg_frame_len is latched at the start of every frame.
  - Values below 60 are clamped to 60.
  - Beats per frame = ceil(len / KEEP_WIDTH).
- DATA state:
  - m_axis_tvalid=1. tdata, tkeep and tlast are held stable while tready=0.
  - The beat advances only when tvalid and tready are both high.
- Byte content, by global byte index b = beat*KEEP_WIDTH + lane:
  - b 0-5: dst MAC, MSB first.
  - b 6-11: src MAC.
  - b 12-13: EtherType.
  - b 14-17: sequence number, big-endian. It starts at 0 for each run and increments per frame.
  - All other bytes: b[7:0].
- tkeep:
  - All ones except on the last beat.
  - On the last beat the low (len mod KEEP_WIDTH) bits are set, or all ones if the remainder is 0.
- Last-beat acceptance:
  - sent_count increments by 1.
  - If cfg_ifg = 0 and the run continues, the next frame's first beat is presented on the next cycle; otherwise the FSM goes to GAP.
- GAP state:
  - tvalid=0 for exactly ifg cycles, then DATA.
  - The FSM goes to IDLE instead when the run is finished (frame_cnt != 0 and that many frames sent) or stop was seen.
- stop handling:
  - stop is sticky until the run ends.
  - stop asserted in IDLE has no effect.
  - stop asserted on the same cycle as the last-beat handshake ends the run after that frame.
- start and stop in the same cycle while in IDLE: the run starts, and exactly one frame is sent.
- busy falls on entry to IDLE.
- sent_count wraps from all ones to 0.

Optional Feature:
- Macro: ETH_PKTGEN_TIMESTAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter is cleared by reset.
  - Its value is captured when each frame's first beat is first presented.
  - The captured value is inserted big-endian at bytes 18-21.
  - Frames shorter than 22 bytes cannot occur, because of the 60-byte clamp.
- When undefined: bytes 18-21 carry b[7:0], and the counter logic is absent.

Decomposition:
- Package eth_pktgen_pkg holds:
  - the FSM state enum (IDLE, DATA, GAP);
  - MIN_FRAME_LEN=60;
  - header byte-offset constants: DST_OFF=0, SRC_OFF=6, TYPE_OFF=12, SEQ_OFF=14, TS_OFF=18.
- Sub-module eth_pktgen_beat: combinational byte-lane mux. Its inputs are the beat index, the latched header fields, the sequence number and the timestamp; its outputs are tdata and tkeep.
- The FSM and counters live in eth_pktgen.

Test Plan:
- DATA_WIDTH=64, len=60, cnt=1, ifg=0, tready=1:
  - 8 beats; beat 7 has tkeep=8'h0F and tlast=1.
  - Bytes 0-5 equal the dst MAC; bytes 14-17 equal 0.
  - sent_count=1; busy falls the cycle after the last beat.
- len=61, cnt=3, ifg=4:
  - Last beat tkeep=8'h1F.
  - Exactly 4 idle cycles between frames.
  - Sequence numbers 0, 1, 2.
- Random tready (50%):
  - tdata, tkeep and tlast are stable whenever tvalid=1 and tready=0.
  - Byte pattern and frame count are intact.
- cnt=0, stop asserted mid-frame 5:
  - Frame 5 completes with tlast, then no further tvalid.
  - sent_count=6 (frames 0-5).
- len=20: clamped; 8 beats with the len=60 tkeep pattern.
- eth_rst_n low mid-frame: outputs go to 0 asynchronously; after release, start produces sequence number 0 and sent_count restarts from 0.

Source files
------------

// File: rtl/eth_pktgen_pkg.sv
// Shared types and constants for the eth_pktgen AXI4-Stream frame generator.
package eth_pktgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int MIN_FRAME_LEN = 60;

  // Header byte offsets within a frame
  localparam int DST_OFF  = 0;
  localparam int SRC_OFF  = 6;
  localparam int TYPE_OFF = 12;
  localparam int SEQ_OFF  = 14;
  localparam int TS_OFF   = 18;

endpackage

// File: rtl/eth_pktgen_beat.sv
// Combinational byte-lane mux: builds tdata/tkeep for one beat of a generated frame.
// With ETH_PKTGEN_TIMESTAMP_EN defined, bytes 18-21 carry the frame timestamp.
module eth_pktgen_beat
  import eth_pktgen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 14,
  localparam int KB        = $clog2(KEEP_WIDTH)
) (
  input  logic [LEN_WIDTH-1:0]  beat_idx,
  input  logic                  last_beat,
  input  logic [KB-1:0]         len_rem,
  input  logic [47:0]           dst_mac,
  input  logic [47:0]           src_mac,
  input  logic [15:0]           ethertype,
  input  logic [31:0]           seq_num,
`ifdef ETH_PKTGEN_TIMESTAMP_EN
  input  logic [31:0]           timestamp,
`endif
  output logic [DATA_WIDTH-1:0] tdata,
  output logic [KEEP_WIDTH-1:0] tkeep
);

  localparam int BW = LEN_WIDTH + KB;
`ifdef ETH_PKTGEN_TIMESTAMP_EN
  localparam int HDR_LEN = TS_OFF + 4;
`else
  localparam int HDR_LEN = TS_OFF;
`endif

  logic [7:0]    hdr [32];
  logic [BW-1:0] b;

  always_comb begin
    for (int i = 0; i < 32; i++) hdr[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      hdr[DST_OFF+i] = dst_mac[47-8*i -: 8];
      hdr[SRC_OFF+i] = src_mac[47-8*i -: 8];
    end
    for (int i = 0; i < 2; i++) hdr[TYPE_OFF+i] = ethertype[15-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      hdr[SEQ_OFF+i] = seq_num[31-8*i -: 8];
`ifdef ETH_PKTGEN_TIMESTAMP_EN
      hdr[TS_OFF+i] = timestamp[31-8*i -: 8];
`endif
    end
  end

  // Global byte index is {beat, lane} because KEEP_WIDTH is a power of two
  always_comb begin
    tdata = '0;
    tkeep = '0;
    b     = '0;
    for (int lane = 0; lane < KEEP_WIDTH; lane++) begin
      b = {beat_idx, KB'(lane)};
      if (b < BW'(HDR_LEN)) tdata[8*lane +: 8] = hdr[b[4:0]];
      else                  tdata[8*lane +: 8] = b[7:0];
      tkeep[lane] = !last_beat || (len_rem == '0) || (KB'(lane) < len_rem);
    end
  end

endmodule

// File: rtl/eth_pktgen.sv
// Parametrised AXI4-Stream Ethernet frame generator with per-frame sequence numbers.
// Define ETH_PKTGEN_TIMESTAMP_EN to insert a 32-bit cycle timestamp at bytes 18-21.
module eth_pktgen
  import eth_pktgen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 14,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk156,
  input  logic                  eth_rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [7:0]            cfg_ifg,
  input  logic [CNT_WIDTH-1:0]  cfg_frame_cnt,
  input  logic [47:0]           cfg_dst_mac,
  input  logic [47:0]           cfg_src_mac,
  input  logic [15:0]           cfg_ethertype,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  sent_count
);

  localparam int KB = $clog2(KEEP_WIDTH);

  state_t                state, state_next;
  logic [LEN_WIDTH-1:0]  beat_idx, last_idx, len_eff;
  logic [KB-1:0]         len_rem;
  logic [CNT_WIDTH-1:0]  frame_cnt_q;
  logic [7:0]            ifg_q, gap_cnt;
  logic [47:0]           dst_q, src_q;
  logic [15:0]           type_q;
  logic [31:0]           seq_num;
  logic                  stop_seen, stop_any;
  logic                  fire, last_beat, last_fire, run_done, new_frame;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [KEEP_WIDTH-1:0] beat_keep;

  assign len_eff   = (cfg_frame_len < LEN_WIDTH'(MIN_FRAME_LEN)) ? LEN_WIDTH'(MIN_FRAME_LEN)
                                                                 : cfg_frame_len;
  assign last_beat = (beat_idx == last_idx);
  assign fire      = m_axis_tvalid && m_axis_tready;
  assign last_fire = fire && last_beat;
  assign stop_any  = stop_seen || stop;
  // seq_num counts frames already completed in this run
  assign run_done  = (frame_cnt_q != '0) && (CNT_WIDTH'(seq_num + 32'd1) == frame_cnt_q);

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    new_frame  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = DATA;
          new_frame  = 1'b1;
        end
      end
      DATA: begin
        if (last_fire) begin
          if (run_done || stop_any) state_next = IDLE;
          else if (ifg_q == 8'd0)   new_frame  = 1'b1;
          else                      state_next = GAP;
        end
      end
      GAP: begin
        if (stop_any) begin
          state_next = IDLE;
        end else if (gap_cnt == ifg_q - 8'd1) begin
          state_next = DATA;
          new_frame  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      frame_cnt_q <= '0;
      ifg_q       <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      type_q      <= '0;
      seq_num     <= '0;
      beat_idx    <= '0;
      last_idx    <= '0;
      len_rem     <= '0;
      gap_cnt     <= '0;
      stop_seen   <= 1'b0;
      sent_count  <= '0;
    end else begin
      if (state == IDLE && start) begin
        frame_cnt_q <= cfg_frame_cnt;
        ifg_q       <= cfg_ifg;
        dst_q       <= cfg_dst_mac;
        src_q       <= cfg_src_mac;
        type_q      <= cfg_ethertype;
        seq_num     <= '0;
      end else if (last_fire) begin
        seq_num <= seq_num + 32'd1;
      end

      if (new_frame) begin
        beat_idx <= '0;
        last_idx <= (len_eff - LEN_WIDTH'(1)) >> KB;
        len_rem  <= len_eff[KB-1:0];
      end else if (fire && !last_beat) begin
        beat_idx <= beat_idx + LEN_WIDTH'(1);
      end

      if (last_fire) sent_count <= sent_count + CNT_WIDTH'(1);

      if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
      else              gap_cnt <= 8'd0;

      // A stop that arrives together with start still allows exactly one frame
      if (state == IDLE) stop_seen <= start && stop;
      else if (stop)     stop_seen <= 1'b1;
    end
  end

`ifdef ETH_PKTGEN_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_q;

  // Captured value equals the counter on the cycle the first beat appears
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (new_frame) ts_q <= ts_cnt + 32'd1;
    end
  end
`endif

  eth_pktgen_beat #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_beat (
    .beat_idx  (beat_idx),
    .last_beat (last_beat),
    .len_rem   (len_rem),
    .dst_mac   (dst_q),
    .src_mac   (src_q),
    .ethertype (type_q),
    .seq_num   (seq_num),
`ifdef ETH_PKTGEN_TIMESTAMP_EN
    .timestamp (ts_q),
`endif
    .tdata     (beat_data),
    .tkeep     (beat_keep)
  );

  assign m_axis_tvalid = (state == DATA);
  assign m_axis_tdata  = m_axis_tvalid ? beat_data : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? beat_keep : '0;
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign m_axis_tuser  = 1'b0;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_eth_pktgen.sv
// Directed self-checking bench for eth_pktgen (64-bit stream, default build).
module tb_eth_pktgen;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int LW = 14;
  localparam int CW = 32;
  localparam logic [47:0] DST   = 48'h0A1B2C3D4E5F;
  localparam logic [47:0] SRC   = 48'h112233445566;
  localparam logic [15:0] ETYPE = 16'h88B5;

  logic          clk156;
  logic          eth_rst_n;
  logic          start;
  logic          stop;
  logic [LW-1:0] cfg_frame_len;
  logic [7:0]    cfg_ifg;
  logic [CW-1:0] cfg_frame_cnt;
  logic [47:0]   cfg_dst_mac;
  logic [47:0]   cfg_src_mac;
  logic [15:0]   cfg_ethertype;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          busy;
  logic [CW-1:0] sent_count;

  int total = 0;
  int bad   = 0;

  logic [7:0]    fbytes [256];
  logic [KW-1:0] last_keep;
  int            frame_beats, idle_before, hold_err, timeout;
  int            stop_beat = -1;
  int            extra;

  eth_pktgen #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .LEN_WIDTH  (LW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk156        (clk156),
    .eth_rst_n     (eth_rst_n),
    .start         (start),
    .stop          (stop),
    .cfg_frame_len (cfg_frame_len),
    .cfg_ifg       (cfg_ifg),
    .cfg_frame_cnt (cfg_frame_cnt),
    .cfg_dst_mac   (cfg_dst_mac),
    .cfg_src_mac   (cfg_src_mac),
    .cfg_ethertype (cfg_ethertype),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .sent_count    (sent_count)
  );

  initial clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expByte(input int b, input logic [31:0] seq);
    if (b < 6)  return 8'(DST >> (8 * (5 - b)));
    if (b < 12) return 8'(SRC >> (8 * (11 - b)));
    if (b < 14) return 8'(ETYPE >> (8 * (13 - b)));
    if (b < 18) return 8'(seq >> (8 * (17 - b)));
    return 8'(b);
  endfunction

  // Configure a run and pulse start across exactly one rising edge
  task automatic applyStimulus(input logic [LW-1:0] len, input logic [7:0] ifg,
                               input logic [CW-1:0] cnt, input logic stp);
    @(negedge clk156);
    cfg_frame_len = len;
    cfg_ifg       = ifg;
    cfg_frame_cnt = cnt;
    start         = 1'b1;
    stop          = stp;
    @(posedge clk156);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Collect one frame, counting idle cycles before it and hold/keep violations
  task automatic getFrame(input bit rnd);
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;
    bit          pend;
    bit          done;
    pend = 0; done = 0; pd = '0; pk = '0; pl = 1'b0;
    frame_beats = 0; idle_before = 0; hold_err = 0; timeout = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk156);
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stop = (stop_beat >= 0) && (frame_beats == stop_beat) && m_axis_tvalid;
      if (m_axis_tvalid) begin
        if (pend && (m_axis_tdata !== pd || m_axis_tkeep !== pk || m_axis_tlast !== pl))
          hold_err++;
        pend = 0;
        if (m_axis_tready) begin
          for (int l = 0; l < KW; l++)
            fbytes[8'(frame_beats * KW + l)] = m_axis_tdata[8*l +: 8];
          last_keep = m_axis_tkeep;
          if (m_axis_tlast) done = 1;
          else if (m_axis_tkeep !== 8'hFF) hold_err++;
          frame_beats++;
        end else begin
          pend = 1;
          pd   = m_axis_tdata;
          pk   = m_axis_tkeep;
          pl   = m_axis_tlast;
        end
      end else begin
        if (pend || frame_beats != 0) hold_err++;
        pend = 0;
        if (frame_beats == 0) idle_before++;
      end
    end
    stop = 1'b0;
    if (!done) timeout = 1;
  endtask

  task automatic checkFrame(input string tag, input int len, input logic [31:0] seq,
                            input logic [7:0] keep, input int beats);
    int mism;
    mism = 0;
    checkOutput({tag, "_timeout"}, 64'(timeout), 64'd0);
    checkOutput({tag, "_beats"}, 64'(frame_beats), 64'(beats));
    checkOutput({tag, "_keep"}, 64'(last_keep), 64'(keep));
    checkOutput({tag, "_hold"}, 64'(hold_err), 64'd0);
    for (int b = 0; b < len; b++)
      if (fbytes[8'(b)] !== expByte(b, seq)) mism++;
    checkOutput({tag, "_bytes"}, 64'(mism), 64'd0);
    checkOutput({tag, "_seq"}, 64'({fbytes[14], fbytes[15], fbytes[16], fbytes[17]}), 64'(seq));
  endtask

  task automatic watchIdle(input int cycles);
    extra = 0;
    repeat (cycles) begin
      @(negedge clk156);
      if (m_axis_tvalid) extra++;
    end
  endtask

  initial begin
    eth_rst_n     = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    cfg_frame_len = '0;
    cfg_ifg       = '0;
    cfg_frame_cnt = '0;
    cfg_dst_mac   = DST;
    cfg_src_mac   = SRC;
    cfg_ethertype = ETYPE;
    m_axis_tready = 1'b1;
    #23;
    checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_tdata", 64'(m_axis_tdata), 64'd0);
    checkOutput("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_sent", 64'(sent_count), 64'd0);
    checkOutput("rst_tuser", 64'(m_axis_tuser), 64'd0);
    @(negedge clk156);
    eth_rst_n = 1'b1;

    $display("[TB] single 60-byte frame");
    applyStimulus(14'd60, 8'd0, 32'd1, 1'b0);
    checkOutput("t1_busy_rise", 64'(busy), 64'd1);
    checkOutput("t1_tvalid_rise", 64'(m_axis_tvalid), 64'd1);
    getFrame(1'b0);
    checkFrame("t1", 60, 32'd0, 8'h0F, 8);
    checkOutput("t1_dst", 64'({fbytes[0], fbytes[1], fbytes[2], fbytes[3], fbytes[4], fbytes[5]}),
                64'(DST));
    checkOutput("t1_busy_last", 64'(busy), 64'd1);
    @(negedge clk156);
    checkOutput("t1_busy_fall", 64'(busy), 64'd0);
    checkOutput("t1_tvalid_off", 64'(m_axis_tvalid), 64'd0);
    checkOutput("t1_sent", 64'(sent_count), 64'd1);

    $display("[TB] three 61-byte frames with ifg=4");
    applyStimulus(14'd61, 8'd4, 32'd3, 1'b0);
    for (int f = 0; f < 3; f++) begin
      getFrame(1'b0);
      checkFrame($sformatf("t2_f%0d", f), 61, 32'(f), 8'h1F, 8);
      checkOutput($sformatf("t2_gap%0d", f), 64'(idle_before), 64'((f == 0) ? 0 : 4));
    end
    @(negedge clk156);
    checkOutput("t2_busy", 64'(busy), 64'd0);
    checkOutput("t2_sent", 64'(sent_count), 64'd4);

    $display("[TB] random tready, four 100-byte frames with ifg=1");
    applyStimulus(14'd100, 8'd1, 32'd4, 1'b0);
    for (int f = 0; f < 4; f++) begin
      getFrame(1'b1);
      checkFrame($sformatf("t3_f%0d", f), 100, 32'(f), 8'h0F, 13);
      checkOutput($sformatf("t3_gap%0d", f), 64'(idle_before), 64'((f == 0) ? 0 : 1));
    end
    m_axis_tready = 1'b1;
    @(negedge clk156);
    checkOutput("t3_busy", 64'(busy), 64'd0);
    checkOutput("t3_sent", 64'(sent_count), 64'd8);

    $display("[TB] endless run stopped during frame 5");
    @(negedge clk156);
    eth_rst_n = 1'b0;
    @(negedge clk156);
    eth_rst_n = 1'b1;
    applyStimulus(14'd64, 8'd2, 32'd0, 1'b0);
    for (int f = 0; f < 6; f++) begin
      stop_beat = (f == 5) ? 3 : -1;
      getFrame(1'b0);
      checkFrame($sformatf("t4_f%0d", f), 64, 32'(f), 8'hFF, 8);
      checkOutput($sformatf("t4_gap%0d", f), 64'(idle_before), 64'((f == 0) ? 0 : 2));
    end
    stop_beat = -1;
    watchIdle(30);
    checkOutput("t4_no_more_valid", 64'(extra), 64'd0);
    checkOutput("t4_sent", 64'(sent_count), 64'd6);
    checkOutput("t4_busy", 64'(busy), 64'd0);

    $display("[TB] 20-byte request clamps to 60");
    applyStimulus(14'd20, 8'd0, 32'd1, 1'b0);
    getFrame(1'b0);
    checkFrame("t5", 60, 32'd0, 8'h0F, 8);
    @(negedge clk156);
    checkOutput("t5_sent", 64'(sent_count), 64'd7);
    checkOutput("t5_busy", 64'(busy), 64'd0);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(14'd60, 8'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk156);
    #2;
    eth_rst_n = 1'b0;
    #1;
    checkOutput("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("t6_tdata", 64'(m_axis_tdata), 64'd0);
    checkOutput("t6_tkeep", 64'(m_axis_tkeep), 64'd0);
    checkOutput("t6_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_sent", 64'(sent_count), 64'd0);
    @(negedge clk156);
    eth_rst_n = 1'b1;
    applyStimulus(14'd60, 8'd0, 32'd2, 1'b0);
    for (int f = 0; f < 2; f++) begin
      getFrame(1'b0);
      checkFrame($sformatf("t6_f%0d", f), 60, 32'(f), 8'h0F, 8);
      checkOutput($sformatf("t6_gap%0d", f), 64'(idle_before), 64'd0);
    end
    @(negedge clk156);
    checkOutput("t6_sent_after", 64'(sent_count), 64'd2);
    checkOutput("t6_busy_after", 64'(busy), 64'd0);

    $display("[TB] stop in idle, then start together with stop");
    @(negedge clk156);
    stop = 1'b1;
    @(negedge clk156);
    stop = 1'b0;
    checkOutput("t7_idle_stop_busy", 64'(busy), 64'd0);
    applyStimulus(14'd60, 8'd0, 32'd0, 1'b1);
    getFrame(1'b0);
    checkFrame("t7", 60, 32'd0, 8'h0F, 8);
    watchIdle(20);
    checkOutput("t7_no_more_valid", 64'(extra), 64'd0);
    checkOutput("t7_sent", 64'(sent_count), 64'd3);
    checkOutput("t7_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
